// File: rtl/fir_pkg.sv
// Shared FIR control encoding and sequencer state type, imported by the sequencer and the accumulator.
// Pure definitions; no logic or latency of its own.
package fir_pkg;

  localparam int CTRL_W     = 3;
  localparam int CTRL_VALID = 0;
  localparam int CTRL_FIRST = 1;
  localparam int CTRL_LAST  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

  function automatic logic [CTRL_W-1:0] ctrl_word(input logic first, input logic last);
    logic [CTRL_W-1:0] w;
    w             = '0;
    w[CTRL_VALID] = 1'b1;
    w[CTRL_FIRST] = first;
    w[CTRL_LAST]  = last;
    return w;
  endfunction

endpackage

// File: rtl/fir_sample_buffer.sv
// TAPS-deep sample delay line: shift-in on enable, synchronous clear, combinational indexed read.
// Write takes effect at the clock edge; a same-edge read returns the pre-shift contents.
module fir_sample_buffer #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_shift,
  input  logic [WIDTH-1:0]        i_data,
  input  logic [$clog2(TAPS)-1:0] i_rd_idx,
  output logic [WIDTH-1:0]        o_rd_data
);

  logic [WIDTH-1:0] r_buf [TAPS];

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      for (int k = 0; k < TAPS; k++) r_buf[k] <= '0;
    end else if (i_shift) begin
      r_buf[0] <= i_data;
      for (int k = 1; k < TAPS; k++) r_buf[k] <= r_buf[k-1];
    end
  end

  assign o_rd_data = r_buf[i_rd_idx];

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR front end: one accepted sample yields TAPS registered (sample, coef, ctrl) pairs, first pair one cycle after accept.
// No output backpressure; input is throttled by o_in_ready, which opens only when idle or on the final tap.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAPS  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [WIDTH-1:0]        i_in_data,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic                    i_flush,
  input  logic                    i_coef_we,
  input  logic [$clog2(TAPS)-1:0] i_coef_addr,
  input  logic [WIDTH-1:0]        i_coef_data,
  output logic [WIDTH-1:0]        o_mult_x,
  output logic [WIDTH-1:0]        o_mult_y,
  output logic [CTRL_W-1:0]       o_mult_ctrl,
  output logic                    o_busy
);

  localparam int                TW       = $clog2(TAPS);
  localparam logic [TW-1:0]     LAST_TAP = TW'(TAPS - 1);
  localparam logic [TW:0]       TAPS_V   = (TW+1)'(TAPS);

  seq_state_t       r_state;
  logic [TW-1:0]    r_tap;
  logic [WIDTH-1:0] r_coef [TAPS];
  logic [WIDTH-1:0] w_buf_rd;
  logic             w_accept;
  logic             w_last;
  logic             w_coef_wr;

  assign w_last     = (r_tap == LAST_TAP);
  assign o_in_ready = !i_flush && ((r_state == IDLE) || (r_state == ISSUE && w_last));
  assign w_accept   = i_in_valid && o_in_ready;
  assign o_busy     = (r_state == ISSUE);
  // Coefficients are only writable while the bank is not being read out.
  assign w_coef_wr  = i_coef_we && (r_state == IDLE) && !w_accept && ({1'b0, i_coef_addr} < TAPS_V);

  fir_sample_buffer #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_flush),
    .i_shift   (w_accept),
    .i_data    (i_in_data),
    .i_rd_idx  (r_tap),
    .o_rd_data (w_buf_rd)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_tap       <= '0;
      o_mult_x    <= '0;
      o_mult_y    <= '0;
      o_mult_ctrl <= '0;
      for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
    end else begin
      if (w_coef_wr) r_coef[i_coef_addr] <= i_coef_data;
      if (i_flush) begin
        r_state     <= IDLE;
        r_tap       <= '0;
        o_mult_ctrl <= '0;
      end else if (r_state == ISSUE) begin
        o_mult_x    <= w_buf_rd;
        o_mult_y    <= r_coef[r_tap];
        o_mult_ctrl <= ctrl_word(r_tap == '0, w_last);
        if (w_last) begin
          r_tap   <= '0;
          r_state <= w_accept ? ISSUE : IDLE;
        end else begin
          r_tap <= r_tap + 1'b1;
        end
      end else begin
        o_mult_ctrl <= '0;
        if (w_accept) begin
          r_state <= ISSUE;
          r_tap   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench: a table of per-cycle stimulus and expected outputs for a TAPS=4 instance,
// plus a hand-written out-of-range coefficient write sequence on a TAPS=5 instance.
module tb_fir_tap_sequencer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // TAPS=4 instance
  logic         a_rst, a_vld, a_rdy, a_flush, a_we, a_busy;
  logic [W-1:0] a_data, a_cdata, a_x, a_y;
  logic [1:0]   a_addr;
  logic [2:0]   a_ctrl;

  // TAPS=5 instance
  logic         b_rst, b_vld, b_rdy, b_flush, b_we, b_busy;
  logic [W-1:0] b_data, b_cdata, b_x, b_y;
  logic [2:0]   b_addr;
  logic [2:0]   b_ctrl;

  fir_tap_sequencer #(.WIDTH(W), .TAPS(4)) dut (
    .i_clk(clk), .i_rst(a_rst), .i_in_data(a_data), .i_in_valid(a_vld), .o_in_ready(a_rdy),
    .i_flush(a_flush), .i_coef_we(a_we), .i_coef_addr(a_addr), .i_coef_data(a_cdata),
    .o_mult_x(a_x), .o_mult_y(a_y), .o_mult_ctrl(a_ctrl), .o_busy(a_busy)
  );

  fir_tap_sequencer #(.WIDTH(W), .TAPS(5)) dut5 (
    .i_clk(clk), .i_rst(b_rst), .i_in_data(b_data), .i_in_valid(b_vld), .o_in_ready(b_rdy),
    .i_flush(b_flush), .i_coef_we(b_we), .i_coef_addr(b_addr), .i_coef_data(b_cdata),
    .o_mult_x(b_x), .o_mult_y(b_y), .o_mult_ctrl(b_ctrl), .o_busy(b_busy)
  );

  typedef struct {
    logic         rst;
    logic         vld;
    logic [W-1:0] d;
    logic         fl;
    logic         we;
    logic [1:0]   a;
    logic [W-1:0] cd;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [2:0]   ec;
    logic         eb;
    logic         er;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int rst, input int vld, input int d, input int fl, input int we,
                              input int a, input int cd, input int ex, input int ey, input int ec,
                              input int eb, input int er);
    vec_t v;
    v.rst = rst[0]; v.vld = vld[0]; v.d = d[W-1:0]; v.fl = fl[0]; v.we = we[0];
    v.a = a[1:0]; v.cd = cd[W-1:0]; v.ex = ex[W-1:0]; v.ey = ey[W-1:0]; v.ec = ec[2:0];
    v.eb = eb[0]; v.er = er[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst vld d fl we a cd | x y ctrl busy rdy
    // coefficients 1,2,3,4 in IDLE
    tbl.push_back(mk(1,0,0,0,1,0,1,  0,0,3'b000,0,1));
    tbl.push_back(mk(1,0,0,0,1,1,2,  0,0,3'b000,0,1));
    tbl.push_back(mk(1,0,0,0,1,2,3,  0,0,3'b000,0,1));
    tbl.push_back(mk(1,0,0,0,1,3,4,  0,0,3'b000,0,1));
    // single sample 5
    tbl.push_back(mk(1,1,5,0,0,0,0,  0,0,3'b000,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  5,1,3'b011,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,2,3'b001,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,3,3'b001,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,4,3'b101,0,1));
    // flush in IDLE clears the delay line; ready drops while flush is high
    tbl.push_back(mk(1,0,0,1,0,0,0,  0,4,3'b000,0,0));
    // samples 1,2,3 with valid held high
    tbl.push_back(mk(1,1,1,0,0,0,0,  0,4,3'b000,1,0));
    tbl.push_back(mk(1,1,2,0,0,0,0,  1,1,3'b011,1,0));
    tbl.push_back(mk(1,1,2,0,0,0,0,  0,2,3'b001,1,0));
    tbl.push_back(mk(1,1,2,0,0,0,0,  0,3,3'b001,1,1));
    tbl.push_back(mk(1,1,2,0,0,0,0,  0,4,3'b101,1,0));
    tbl.push_back(mk(1,1,3,0,0,0,0,  2,1,3'b011,1,0));
    tbl.push_back(mk(1,1,3,0,0,0,0,  1,2,3'b001,1,0));
    tbl.push_back(mk(1,1,3,0,0,0,0,  0,3,3'b001,1,1));
    tbl.push_back(mk(1,1,3,0,0,0,0,  0,4,3'b101,1,0));
    // coef write to addr 0 during ISSUE is ignored; third block x=3,2,1,0
    tbl.push_back(mk(1,0,0,0,1,0,9,  3,1,3'b011,1,0));
    tbl.push_back(mk(1,0,0,0,1,0,9,  2,2,3'b001,1,0));
    tbl.push_back(mk(1,0,0,0,1,0,9,  1,3,3'b001,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,4,3'b101,0,1));
    // same write in IDLE is applied
    tbl.push_back(mk(1,0,0,0,1,0,9,  0,4,3'b000,0,1));
    // write coinciding with an accept is ignored (coef[1] stays 2); last tap reads old buf[3]
    tbl.push_back(mk(1,1,6,0,1,1,8,  0,4,3'b000,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  6,9,3'b011,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  3,2,3'b001,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  2,3,3'b001,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,  1,4,3'b101,0,1));
    // flush at tap 2 with valid high: ctrl drops, x/y hold, no accept
    tbl.push_back(mk(1,1,8,0,0,0,0,  1,4,3'b000,1,0));
    tbl.push_back(mk(1,1,8,0,0,0,0,  8,9,3'b011,1,0));
    tbl.push_back(mk(1,1,8,0,0,0,0,  6,2,3'b001,1,0));
    tbl.push_back(mk(1,1,8,1,0,0,0,  6,2,3'b000,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  6,2,3'b000,0,1));
    // next sample 7 sees a cleared delay line
    tbl.push_back(mk(1,1,7,0,0,0,0,  6,2,3'b000,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  7,9,3'b011,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,2,3'b001,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,3,3'b001,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,4,3'b101,0,1));
    // reset at tap 1 aborts the issue and clears the coefficient bank
    tbl.push_back(mk(1,1,4,0,0,0,0,  0,4,3'b000,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  4,9,3'b011,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,  0,0,3'b000,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,0,3'b000,0,1));
    tbl.push_back(mk(1,1,5,0,0,0,0,  0,0,3'b000,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  5,0,3'b011,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,0,3'b001,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,0,3'b001,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,  0,0,3'b101,0,1));

    a_rst = 1'b0; a_vld = 1'b0; a_data = '0; a_flush = 1'b0; a_we = 1'b0; a_addr = '0; a_cdata = '0;
    b_rst = 1'b0; b_vld = 1'b0; b_data = '0; b_flush = 1'b0; b_we = 1'b0; b_addr = '0; b_cdata = '0;
    tick();
    tick();
    chk("reset_x",     -1, a_x,    0);
    chk("reset_y",     -1, a_y,    0);
    chk("reset_ctrl",  -1, a_ctrl, 0);
    chk("reset_busy",  -1, a_busy, 0);
    chk("reset_ready", -1, a_rdy,  1);
    a_rst = 1'b1;
    b_rst = 1'b1;

    foreach (tbl[i]) begin
      a_rst = tbl[i].rst; a_vld = tbl[i].vld; a_data = tbl[i].d; a_flush = tbl[i].fl;
      a_we = tbl[i].we; a_addr = tbl[i].a; a_cdata = tbl[i].cd;
      tick();
      chk("x",     i, a_x,    tbl[i].ex);
      chk("y",     i, a_y,    tbl[i].ey);
      chk("ctrl",  i, a_ctrl, tbl[i].ec);
      chk("busy",  i, a_busy, tbl[i].eb);
      chk("ready", i, a_rdy,  tbl[i].er);
    end
    a_rst = 1'b1; a_vld = 1'b0; a_we = 1'b0; a_flush = 1'b0;

    // TAPS=5: load 10..14, then writes to addresses 5..7 must leave the bank alone
    for (int k = 0; k < 5; k++) begin
      b_we = 1'b1; b_addr = 3'(k); b_cdata = 8'(10 + k);
      tick();
    end
    for (int k = 5; k < 8; k++) begin
      b_we = 1'b1; b_addr = 3'(k); b_cdata = 8'(90 + k);
      tick();
    end
    b_we = 1'b0;
    b_vld = 1'b1; b_data = 8'd1;
    tick();
    b_vld = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t5_x",    t, b_x,    (t == 0) ? 1 : 0);
      chk("t5_y",    t, b_y,    10 + t);
      chk("t5_ctrl", t, b_ctrl, {(t == 4), (t == 0), 1'b1});
    end
    tick();
    chk("t5_ctrl_idle", 5, b_ctrl, 0);
    chk("t5_busy_idle", 5, b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
